// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ready port between the fetch unit (master) and memory (slave).
// At most one request is outstanding; req/addr hold until rdy is seen.
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        rdy;
    logic [31:0] data;

    modport master (output req, output addr, input rdy, input data);
    modport slave  (input req, input addr, output rdy, output data);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the imem port, resolves EXE-stage redirects
// and presents the IF/ID register to decode, with a one-entry skid buffer for if_en stalls.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_FETCH | request outstanding at pc; response goes to IF/ID or skid buffer
// S_KILL  | request outstanding on a wrong path; response dropped, then redirect
// S_HOLD  | no request; skid buffer full, waiting for if_en or a redirect
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_rst,
    input  logic         if_en,
    input  logic [2:0]   pc_src_exe,
    input  logic         rs_eq_rt_exe,
    input  logic [31:0]  jump_target_exe,
    input  logic [31:0]  jr_target_exe,
    input  logic [31:0]  branch_target_exe,
    if_fetch_unit_if.master imem,
    output logic [31:0]  inst_if,
    output logic [31:0]  pc_if,
    output logic [31:0]  pc_plus4_if,
    output logic         if_valid,
    output logic         fetch_stall
);

    localparam logic [2:0] PC_JUMP = 3'd1;
    localparam logic [2:0] PC_JR   = 3'd2;
    localparam logic [2:0] PC_BEQ  = 3'd3;
    localparam logic [2:0] PC_BNE  = 3'd4;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_KILL  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] kill_target;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic        req_q;
    logic        in_rst;
    logic        taken;
    logic [31:0] target;

    assign in_rst = rst | if_rst;

    always_comb begin
        taken  = 1'b0;
        target = branch_target_exe;
        case (pc_src_exe)
            PC_JUMP: begin
                taken  = 1'b1;
                target = jump_target_exe;
            end
            PC_JR: begin
                taken  = 1'b1;
                target = jr_target_exe;
            end
            PC_BEQ:  taken = rs_eq_rt_exe;
            PC_BNE:  taken = ~rs_eq_rt_exe;
            default: taken = 1'b0;
        endcase
    end

    // The request is suppressed combinationally during the reset cycle itself.
    assign imem.req    = req_q & ~in_rst;
    assign imem.addr   = {pc[31:2], 2'b00};
    assign pc_plus4_if = pc_if + 32'd4;
    assign fetch_stall = ~in_rst & ~taken &
                         (((state == S_FETCH) & ~imem.rdy) | (state == S_KILL));

    always_ff @(posedge clk) begin
        if (in_rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            kill_target <= 32'd0;
            skid_inst   <= 32'd0;
            skid_pc     <= 32'd0;
            req_q       <= 1'b1;
            inst_if     <= 32'd0;
            pc_if       <= 32'd0;
            if_valid    <= 1'b0;
        end else begin
            // Redirects always insert a bubble so wrong-path code never reaches decode.
            if (if_en) begin
                if (taken) begin
                    inst_if  <= 32'd0;
                    if_valid <= 1'b0;
                end else if (state == S_HOLD) begin
                    inst_if  <= skid_inst;
                    pc_if    <= skid_pc;
                    if_valid <= 1'b1;
                end else if (state == S_FETCH && imem.rdy) begin
                    inst_if  <= imem.data;
                    pc_if    <= pc;
                    if_valid <= 1'b1;
                end else begin
                    inst_if  <= 32'd0;
                    if_valid <= 1'b0;
                end
            end

            case (state)
                S_FETCH: begin
                    if (taken) begin
                        if (imem.rdy) begin
                            pc <= target;
                        end else begin
                            kill_target <= target;
                            state       <= S_KILL;
                        end
                    end else if (imem.rdy) begin
                        pc <= pc + 32'd4;
                        if (!if_en) begin
                            skid_inst <= imem.data;
                            skid_pc   <= pc;
                            state     <= S_HOLD;
                            req_q     <= 1'b0;
                        end
                    end
                end
                S_KILL: begin
                    if (imem.rdy) begin
                        pc    <= taken ? target : kill_target;
                        state <= S_FETCH;
                    end else if (taken) begin
                        kill_target <= target;
                    end
                end
                S_HOLD: begin
                    if (taken) begin
                        pc    <= target;
                        state <= S_FETCH;
                        req_q <= 1'b1;
                    end else if (if_en) begin
                        state <= S_FETCH;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_FETCH;
                    req_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        if_rst;
    logic        if_en;
    logic [2:0]  pc_src_exe;
    logic        rs_eq_rt_exe;
    logic [31:0] jump_target_exe;
    logic [31:0] jr_target_exe;
    logic [31:0] branch_target_exe;
    logic [31:0] inst_if;
    logic [31:0] pc_if;
    logic [31:0] pc_plus4_if;
    logic        if_valid;
    logic        fetch_stall;

    if_fetch_unit_if imem();

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .if_rst            (if_rst),
        .if_en             (if_en),
        .pc_src_exe        (pc_src_exe),
        .rs_eq_rt_exe      (rs_eq_rt_exe),
        .jump_target_exe   (jump_target_exe),
        .jr_target_exe     (jr_target_exe),
        .branch_target_exe (branch_target_exe),
        .imem              (imem),
        .inst_if           (inst_if),
        .pc_if             (pc_if),
        .pc_plus4_if       (pc_plus4_if),
        .if_valid          (if_valid),
        .fetch_stall       (fetch_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // memory environment
    int lat = 1;
    int age = 0;
    bit stray_rdy = 1'b0;

    // reference model
    logic [31:0] m_pc    = RST_PC;
    logic [31:0] m_inst  = 32'd0;
    logic [31:0] m_pcif  = 32'd0;
    logic        m_valid = 1'b0;
    bit          m_doomed = 1'b0;
    logic [31:0] m_tgt   = 32'd0;
    logic [63:0] buf_q[$];

    // values seen at the last sample point, for literal checks
    logic        s_req, s_stall, s_valid;
    logic [31:0] s_addr, s_inst, s_pcif, s_plus4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic step(input logic r, input logic ir, input logic en, input logic [2:0] src,
                        input logic eq, input logic [31:0] jt, input logic [31:0] jrt,
                        input logic [31:0] bt);
        bit          tk;
        logic [31:0] tg;
        bit          rn;
        bit          e_req;
        bit          e_stall;
        bit          req_c;
        bit          rdy_c;
        logic [31:0] data_c;
        logic [63:0] ent;

        @(negedge clk);
        rst = r; if_rst = ir; if_en = en; pc_src_exe = src; rs_eq_rt_exe = eq;
        jump_target_exe = jt; jr_target_exe = jrt; branch_target_exe = bt;
        #1;
        if (imem.req) imem.rdy = (age + 1 >= lat);
        else          imem.rdy = stray_rdy;
        imem.data = imem.rdy ? mem_word(imem.addr) : 32'hDEAD_BEEF;
        #1;

        tk = (src == 3'd1) || (src == 3'd2) || (src == 3'd3 && eq) || (src == 3'd4 && !eq);
        tg = (src == 3'd1) ? jt : (src == 3'd2) ? jrt : bt;
        rn = r || ir;
        e_req   = !rn && (buf_q.size() == 0);
        e_stall = !rn && !tk && (m_doomed || (e_req && !imem.rdy));

        s_req = imem.req; s_addr = imem.addr; s_stall = fetch_stall; s_valid = if_valid;
        s_inst = inst_if; s_pcif = pc_if; s_plus4 = pc_plus4_if;

        if (chk_en) begin
            check("imem_req", {31'd0, imem.req}, {31'd0, e_req});
            if (e_req) check("imem_addr", imem.addr, {m_pc[31:2], 2'b00});
            check("fetch_stall", {31'd0, fetch_stall}, {31'd0, e_stall});
            check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
            check("inst_if", inst_if, m_inst);
            check("pc_if", pc_if, m_pcif);
            check("pc_plus4_if", pc_plus4_if, m_pcif + 32'd4);
        end
        n_vec++;

        req_c = imem.req; rdy_c = imem.rdy; data_c = imem.data;
        @(posedge clk);

        if (rn || !req_c || rdy_c) age = 0;
        else                       age++;

        if (rn) begin
            m_pc = RST_PC; m_inst = 32'd0; m_pcif = 32'd0; m_valid = 1'b0;
            m_doomed = 1'b0; m_tgt = 32'd0; buf_q.delete();
        end else begin
            if (en) begin
                if (tk) begin
                    m_inst = 32'd0; m_valid = 1'b0;
                end else if (buf_q.size() > 0) begin
                    ent = buf_q[0];
                    m_inst = ent[63:32]; m_pcif = ent[31:0]; m_valid = 1'b1;
                end else if (e_req && rdy_c && !m_doomed) begin
                    m_inst = data_c; m_pcif = m_pc; m_valid = 1'b1;
                end else begin
                    m_inst = 32'd0; m_valid = 1'b0;
                end
            end
            if (buf_q.size() > 0) begin
                if (tk) begin
                    buf_q.delete(); m_pc = tg;
                end else if (en) begin
                    buf_q.delete();
                end
            end else if (m_doomed) begin
                if (rdy_c) begin
                    m_pc = tk ? tg : m_tgt; m_doomed = 1'b0;
                end else if (tk) begin
                    m_tgt = tg;
                end
            end else if (tk) begin
                if (rdy_c) m_pc = tg;
                else begin
                    m_doomed = 1'b1; m_tgt = tg;
                end
            end else if (rdy_c) begin
                if (!en) buf_q.push_back({data_c, m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic run(input logic en);
        step(1'b0, 1'b0, en, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1; if_rst = 1'b0; if_en = 1'b1; pc_src_exe = 3'd0; rs_eq_rt_exe = 1'b0;
        jump_target_exe = 32'd0; jr_target_exe = 32'd0; branch_target_exe = 32'd0;
        imem.rdy = 1'b0; imem.data = 32'd0;

        // power-up reset cycle: registers are not yet defined
        step(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        chk_en = 1'b1;

        // R: reset cycle with reset-value outputs
        step(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        check("rst_req", {31'd0, s_req}, 32'd0);
        check("rst_stall", {31'd0, s_stall}, 32'd0);
        check("rst_inst", s_inst, 32'd0);
        check("rst_pc_if", s_pcif, 32'd0);
        check("rst_plus4", s_plus4, 32'd4);
        check("rst_valid", {31'd0, s_valid}, 32'd0);

        run(1'b1);                                                    // R+1
        check("first_addr", s_addr, 32'h100);
        check("first_req", {31'd0, s_req}, 32'd1);
        run(1'b1);                                                    // R+2
        check("stream0_pc", s_pcif, 32'h100);
        check("stream0_inst", s_inst, ~32'h100);
        check("stream0_valid", {31'd0, s_valid}, 32'd1);
        run(1'b1);                                                    // R+3
        check("stream1_pc", s_pcif, 32'h104);

        // if_en low for four cycles at pc_if=0x108
        run(1'b0);                                                    // R+4
        check("stall_entry_pc", s_pcif, 32'h108);
        check("stall_buf_addr", s_addr, 32'h10C);
        for (int i = 0; i < 3; i++) begin
            run(1'b0);                                                // R+5..R+7
            check("stall_req_low", {31'd0, s_req}, 32'd0);
            check("stall_pc_held", s_pcif, 32'h108);
        end
        run(1'b1);                                                    // R+8
        check("release_pc_held", s_pcif, 32'h108);
        run(1'b1);                                                    // R+9
        check("release_buf_pc", s_pcif, 32'h10C);
        check("release_addr", s_addr, 32'h110);
        // taken BEQ at R+10
        step(1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 32'd0, 32'd0, 32'h200);
        check("release_next_pc", s_pcif, 32'h110);
        run(1'b1);                                                    // R+11
        check("beq_addr", s_addr, 32'h200);
        check("beq_bubble", {31'd0, s_valid}, 32'd0);
        // not-taken BNE at R+12
        step(1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 32'd0, 32'd0, 32'h300);
        check("beq_target_pc", s_pcif, 32'h200);
        run(1'b1);                                                    // R+13
        check("bne_seq_pc", s_pcif, 32'h204);

        // JR redirect in wait cycle 1 of a 3-cycle access
        lat = 3;
        step(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 32'd0, 32'h40, 32'd0);     // R+14
        check("wait_addr0", s_addr, 32'h20C);
        run(1'b1);                                                    // R+15
        check("wait_addr1", s_addr, 32'h20C);
        check("wait_stall1", {31'd0, s_stall}, 32'd1);
        check("wait_bubble", {31'd0, s_valid}, 32'd0);
        run(1'b1);                                                    // R+16
        check("wait_addr2", s_addr, 32'h20C);
        check("wait_stall2", {31'd0, s_stall}, 32'd1);
        run(1'b1);                                                    // R+17
        check("jr_addr", s_addr, 32'h40);
        check("jr_discard", {31'd0, s_valid}, 32'd0);
        run(1'b1);
        run(1'b1);                                                    // R+19
        // jump into KILL at R+20, then if_rst while the late response arrives
        step(1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 32'h80, 32'd0, 32'd0);
        check("jr_target_pc", s_pcif, 32'h40);
        run(1'b1);                                                    // R+21
        check("kill_stall", {31'd0, s_stall}, 32'd1);
        stray_rdy = 1'b1;
        step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);      // R+22
        check("ifrst_req", {31'd0, s_req}, 32'd0);
        check("ifrst_stall", {31'd0, s_stall}, 32'd0);
        stray_rdy = 1'b0;
        lat = 1;
        run(1'b1);                                                    // R+23
        check("ifrst_addr", s_addr, RST_PC);
        check("ifrst_inst", s_inst, 32'd0);
        check("ifrst_pc_if", s_pcif, 32'd0);
        check("ifrst_plus4", s_plus4, 32'd4);
        check("ifrst_valid", {31'd0, s_valid}, 32'd0);

        // wrap-around from the top of the address space
        step(1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 32'hFFFF_FFFC, 32'd0, 32'd0);
        check("ifrst_first_pc", s_pcif, RST_PC);
        run(1'b1);
        check("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
        run(1'b1);
        check("wrap_addr_zero", s_addr, 32'h0);
        check("wrap_pc_top", s_pcif, 32'hFFFF_FFFC);
        run(1'b1);
        check("wrap_pc_zero", s_pcif, 32'h0);
        check("wrap_valid", {31'd0, s_valid}, 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] src;
            logic       r, ir;
            src = ($urandom_range(0, 15) < 9) ? 3'd0 : 3'($urandom_range(0, 7));
            r   = ($urandom_range(0, 199) == 0);
            ir  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) == 0) lat = $urandom_range(1, 4);
            stray_rdy = $urandom_range(0, 1);
            step(r, ir, ($urandom_range(0, 3) != 0), src, 1'($urandom_range(0, 1)),
                 $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
